program_sequencer_stack: RTL
============================

PROGRAM_SEQUENCER_STACK -- requirements
Module: program_sequencer_stack

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width.
REQ-002 Parameter JADDR_W, default 4, absolute-jump field width; SHALL satisfy JADDR_W <= ADDR_W.
REQ-003 Parameter REL_W, default 5, signed relative-branch offset width.
REQ-004 Parameter STACK_DEPTH, default 4, return-address stack entries; SHALL be >= 1.
REQ-005 clk  in  1  single system clock; all state updates on rising edge.
REQ-006 sync_reset  in  1  reset, synchronous, active-high.
REQ-007 jmp  in  1  unconditional absolute jump.
REQ-008 jmp_nz  in  1  conditional absolute jump request.
REQ-009 dont_jmp  in  1  condition flag; suppresses jmp_nz when 1.
REQ-010 rel_br  in  1  unconditional relative branch.
REQ-011 rel_off  in  REL_W  two's-complement branch offset.
REQ-012 call  in  1  subroutine call to jmp_addr.
REQ-013 ret  in  1  return to popped address.
REQ-014 jmp_addr  in  JADDR_W  absolute target upper bits.
REQ-015 pm_addr  out  ADDR_W  next fetch address, combinational.
REQ-016 pc  out  ADDR_W  current address, registered.
REQ-017 stack_full / stack_empty  out  1 each  occupancy flags, combinational from stack pointer.
REQ-018 stack_err  out  1  sticky overflow/underflow flag.

Function
REQ-019 pc SHALL load pm_addr on every rising clk edge.
REQ-020 Absolute target SHALL be {jmp_addr, (ADDR_W-JADDR_W) zeros}.
REQ-021 pm_addr priority, highest first: sync_reset -> 0; ret; call; rel_br; jmp; jmp_nz & !dont_jmp; else pc+1.
REQ-022 ret with stack non-empty: pm_addr = top entry; pop at clock edge.
REQ-023 ret with stack empty: pm_addr = pc+1, no pop, stack_err set at edge.
REQ-024 call with stack non-full: pm_addr = absolute target; push pc+1 at edge.
REQ-025 call with stack full: pm_addr = pc+1, no push, stack contents unchanged, stack_err set at edge.
REQ-026 call and ret both asserted: ret SHALL win; call ignored, no push, no error from call.
REQ-027 rel_br: pm_addr = pc + 1 + sign-extended rel_off, modulo 2^ADDR_W.
REQ-028 All address arithmetic SHALL wrap modulo 2^ADDR_W (pc = all-ones increments to 0; pushed pc+1 wraps likewise).
REQ-029 Stack is LIFO; occupancy 0..STACK_DEPTH; stack_empty = (occupancy==0), stack_full = (occupancy==STACK_DEPTH).
REQ-030 stack_err SHALL stay 1 until sync_reset; it does not alter sequencing.
REQ-031 No input is registered; latency from control input to pm_addr is zero cycles, to pc one cycle.

Reset
REQ-032 During sync_reset high: pm_addr = 0 combinationally, independent of other inputs.
REQ-033 At the edge with sync_reset high: pc <= 0, occupancy <= 0, stack_err <= 0; stack entries need not be cleared.
REQ-034 Reset asserted mid-subroutine SHALL discard all pending return addresses; first ret after reset underflows.

Structure
REQ-035 Parameter defaults and the sign-extension width rule SHALL live in a shared sequencer include/package used by this block and its bench.
REQ-036 The return stack SHALL be a sub-module pc_stack (push, pop, data in/out, full, empty), parametrised by ADDR_W and STACK_DEPTH.
REQ-037 Top-level holds only next-address mux, pc register and error flag.

Verification
REQ-038 Reset then 3 idle cycles -> pc sequence 0,1,2,3; pm_addr 0 while sync_reset high.
REQ-039 pc=0x05, call, jmp_addr=0x3 -> pm_addr 0x30, next pc 0x30; later ret -> pm_addr 0x06; stack_empty returns to 1.
REQ-040 Five nested calls with STACK_DEPTH=4 -> 5th call yields pm_addr=pc+1, stack_err=1; four rets return in LIFO order, 5th ret underflows with pm_addr=pc+1.
REQ-041 pc=0x02, rel_br, rel_off=-4 (5'b11100) -> pm_addr 0xFF; pc=0xFE, rel_br, rel_off=+3 -> pm_addr 0x02.
REQ-042 jmp_nz=1, dont_jmp=1 -> pc+1; dont_jmp=0 -> absolute target; jmp=1 with call=1 -> call taken, push occurs.
REQ-043 Two calls then sync_reset pulse -> pc=0, stack_empty=1, stack_err=0; subsequent ret -> stack_err=1.

Source files
------------

// File: rtl/program_sequencer_stack_pkg.sv
// Shared sequencer definitions: parameter defaults, next-address source encoding
// and the relative-offset sign-extension rule used by the sequencer and its bench.
package program_sequencer_stack_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_JADDR_W     = 4;
    localparam int DEF_REL_W       = 5;
    localparam int DEF_STACK_DEPTH = 4;

    localparam int EXT_W = 32;

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_RET,
        SRC_CALL,
        SRC_REL,
        SRC_ABS,
        SRC_INC
    } next_src_e;

    // Treat the low 'width' bits of value as two's complement and extend to EXT_W;
    // callers truncate the result to the address width, which gives modulo wrap.
    function automatic logic [EXT_W-1:0] sext(input logic [EXT_W-1:0] value, input int width);
        logic signed [EXT_W-1:0] shifted;
        shifted = value << (EXT_W - width);
        return shifted >>> (EXT_W - width);
    endfunction

endpackage

// File: rtl/program_sequencer_stack_if.sv
// Control/status bundle between an instruction decoder (master) and the sequencer (slave).
interface program_sequencer_stack_if
    import program_sequencer_stack_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int JADDR_W = DEF_JADDR_W,
    parameter int REL_W   = DEF_REL_W
) ();

    logic               jmp;
    logic               jmp_nz;
    logic               dont_jmp;
    logic               rel_br;
    logic [REL_W-1:0]   rel_off;
    logic               call;
    logic               ret;
    logic [JADDR_W-1:0] jmp_addr;
    logic [ADDR_W-1:0]  pm_addr;
    logic [ADDR_W-1:0]  pc;
    logic               stack_full;
    logic               stack_empty;
    logic               stack_err;

    modport master (
        output jmp, jmp_nz, dont_jmp, rel_br, rel_off, call, ret, jmp_addr,
        input  pm_addr, pc, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  jmp, jmp_nz, dont_jmp, rel_br, rel_off, call, ret, jmp_addr,
        output pm_addr, pc, stack_full, stack_empty, stack_err
    );

endinterface

// File: rtl/program_sequencer_stack_pc_stack.sv
// LIFO of return addresses; push/pop requests that would overflow/underflow are ignored.
module pc_stack
    import program_sequencer_stack_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [PTR_W-1:0]  sp;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              do_push;
    logic              do_pop;

    assign wr_idx  = sp[IDX_W-1:0];
    assign rd_idx  = IDX_W'(sp - PTR_W'(1));
    assign empty   = (sp == '0);
    assign full    = (sp == PTR_W'(STACK_DEPTH));
    assign dout    = empty ? '0 : mem[rd_idx];
    assign do_push = push && !full && !sync_reset;
    assign do_pop  = pop && !empty && !sync_reset;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + PTR_W'(1);
        end else if (do_pop) begin
            sp <= sp - PTR_W'(1);
        end
    end

    // Entries are left stale on reset; the pointer alone defines occupancy.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/program_sequencer_stack.sv
// Program sequencer: next-fetch-address mux, pc register and sticky stack error flag.
module program_sequencer_stack
    import program_sequencer_stack_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int JADDR_W     = DEF_JADDR_W,
    parameter int REL_W       = DEF_REL_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                      clk,
    input  logic                      sync_reset,
    program_sequencer_stack_if.slave  bus
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] abs_tgt;
    logic [ADDR_W-1:0] rel_tgt;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;
    logic              do_push;
    logic              do_pop;
    logic              err_q;
    logic              err_set;
    next_src_e         src;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign abs_tgt = ADDR_W'(bus.jmp_addr) << (ADDR_W - JADDR_W);
    assign rel_tgt = pc_inc + ADDR_W'(sext(EXT_W'(bus.rel_off), REL_W));

    // A blocked call or ret falls through to pc+1 rather than to lower-priority requests.
    always_comb begin
        src = SRC_INC;
        if (sync_reset) begin
            src = SRC_RESET;
        end else if (bus.ret) begin
            src = stk_empty ? SRC_INC : SRC_RET;
        end else if (bus.call) begin
            src = stk_full ? SRC_INC : SRC_CALL;
        end else if (bus.rel_br) begin
            src = SRC_REL;
        end else if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) begin
            src = SRC_ABS;
        end
    end

    always_comb begin
        next_addr = pc_inc;
        case (src)
            SRC_RESET:         next_addr = '0;
            SRC_RET:           next_addr = stk_top;
            SRC_CALL, SRC_ABS: next_addr = abs_tgt;
            SRC_REL:           next_addr = rel_tgt;
            default:           next_addr = pc_inc;
        endcase
    end

    assign do_push = (src == SRC_CALL);
    assign do_pop  = (src == SRC_RET);
    assign err_set = !sync_reset && (bus.ret ? stk_empty : (bus.call && stk_full));

    pc_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_pc_stack (
        .clk        (clk),
        .sync_reset (sync_reset),
        .push       (do_push),
        .pop        (do_pop),
        .din        (pc_inc),
        .dout       (stk_top),
        .full       (stk_full),
        .empty      (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= next_addr;
            err_q <= err_q || err_set;
        end
    end

    assign bus.pm_addr     = next_addr;
    assign bus.pc          = pc_q;
    assign bus.stack_full  = stk_full;
    assign bus.stack_empty = stk_empty;
    assign bus.stack_err   = err_q;

endmodule
